// File: rtl/div_if.sv
// Execute-stage <-> divide sequencer handshake bundle.
// master = execute stage (drives operands/start/annul), slave = div_seq.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract DIV/DIVU sequencer, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish at acceptance when |dividend| < |divisor|.
module div_seq (
    input  logic clk,
    input  logic rst,
    div_if.slave div
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] dvs_q, dvs_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic        sdiv_q, sdiv_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    logic signed [31:0] op1_s, op2_s;
    logic               neg1, neg2;
    logic [31:0]        mag1, mag2;
    logic               early;

    assign op1_s = div.opdata1_i;
    assign op2_s = div.opdata2_i;
    assign neg1  = div.signed_div_i && (op1_s < 0);
    assign neg2  = div.signed_div_i && (op2_s < 0);
    assign mag1  = neg_if(div.opdata1_i, neg1);
    assign mag2  = neg_if(div.opdata2_i, neg2);

`ifdef DIV_EARLY_OUT_EN
    assign early = (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    // Stage ON: shift {rem, dvd} left, trial-subtract divisor from the 33-bit top.
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign shifted = {work_q, 1'b0};
    assign trial   = shifted[64:32] - {1'b0, dvs_q};
    assign quo_fix = neg_if(work_q[31:0],  sdiv_q && (sign1_q ^ sign2_q));
    assign rem_fix = neg_if(work_q[63:32], sdiv_q && sign1_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        sdiv_d   = sdiv_q;
        result_d = result_q;
        ready_d  = ready_q;
        busy_d   = busy_q;

        case (state_q)
            FREE: begin
                if (div.start_i && !div.annul_i) begin
                    if (div.opdata2_i == 32'h0) begin
                        state_d = BYZERO;
                        busy_d  = 1'b1;
                    end else if (early) begin
                        state_d  = END;
                        result_d = {div.opdata1_i, 32'h0};
                        ready_d  = 1'b1;
                    end else begin
                        work_d  = {32'h0, mag1};
                        dvs_d   = mag2;
                        sign1_d = div.opdata1_i[31];
                        sign2_d = div.opdata2_i[31];
                        sdiv_d  = div.signed_div_i;
                        cnt_d   = 6'd0;
                        busy_d  = 1'b1;
                        state_d = ON;
                    end
                end
            end
            BYZERO: begin
                state_d  = div.annul_i ? FREE : END;
                result_d = 64'h0;
                busy_d   = 1'b0;
                ready_d  = !div.annul_i;
            end
            ON: begin
                if (div.annul_i) begin
                    state_d  = FREE;
                    result_d = 64'h0;
                    busy_d   = 1'b0;
                    ready_d  = 1'b0;
                end else if (cnt_q == 6'd32) begin
                    state_d  = END;
                    result_d = {rem_fix, quo_fix};
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                end else begin
                    work_d = trial[32] ? shifted[63:0]
                                       : {trial[31:0], shifted[31:1], 1'b1};
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            END: begin
                if (!div.start_i || div.annul_i) begin
                    state_d  = FREE;
                    result_d = 64'h0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // Datapath registers carry no reset; only control and the visible outputs do.
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        dvs_q   <= dvs_d;
        sign1_q <= sign1_d;
        sign2_q <= sign2_d;
        sdiv_q  <= sdiv_d;
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= 6'd0;
            result_q <= 64'h0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign div.result_o = result_q;
    assign div.ready_o  = ready_q;
    assign div.busy_o   = busy_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected {rem, quo}, latency and busy length.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_if dif ();
    div_seq dut (.clk(clk), .rst(rst), .div(dif));

    typedef struct packed {
        logic [63:0] res;
        logic [7:0]  lat;
        logic [7:0]  busy_n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv;
        logic [63:0] q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = 64'(sa / sbv);
            r   = 64'(sa % sbv);
        end else begin
            q = {32'h0, a} / {32'h0, b};
            r = {32'h0, a} % {32'h0, b};
        end
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic is_early(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        return (b != 32'h0) && (mag(s, a) < mag(s, b));
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        int   n, nb;
        logic got;
        e.res    = model(s, a, b);
        e.lat    = (b == 32'h0) ? 8'd2 : (is_early(s, a, b) ? 8'd1 : 8'd34);
        e.busy_n = (b == 32'h0) ? 8'd1 : (is_early(s, a, b) ? 8'd0 : 8'd33);
        sb.push_back(e);

        @(negedge clk);
        dif.signed_div_i = s;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b0;
        n = 0; nb = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                dif.opdata1_i = $urandom;
                dif.opdata2_i = $urandom;
            end
            if (dif.busy_o) nb++;
            if (dif.ready_o) got = 1'b1;
        end
        e = sb.pop_front();
        check_int({tag, " ready_seen"}, int'(got), 1);
        check64({tag, " result"}, dif.result_o, e.res);
        check_int({tag, " latency"}, n, int'(e.lat));
        check_int({tag, " busy_cycles"}, nb, int'(e.busy_n));

        @(posedge clk);
        @(negedge clk);
        check64({tag, " result_hold"}, dif.result_o, e.res);
        check_int({tag, " ready_hold"}, int'(dif.ready_o), 1);

        dif.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check64({tag, " result_clear"}, dif.result_o, 64'h0);
        check_int({tag, " ready_clear"}, int'(dif.ready_o), 0);
        check_int({tag, " busy_clear"}, int'(dif.busy_o), 0);
    endtask

    task automatic check_idle(input string tag);
        check64({tag, " result"}, dif.result_o, 64'h0);
        check_int({tag, " ready"}, int'(dif.ready_o), 0);
        check_int({tag, " busy"}, int'(dif.busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst              = 1'b1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'h0;
        dif.opdata2_i    = 32'h0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_div(1'b0, 32'd1234, 32'h0, "divu_by0");
        run_div(1'b1, 32'h8000_0000, 32'h0, "div_by0");
        run_div(1'b0, 32'd5, 32'd9, "divu_5_9");
        run_div(1'b1, 32'hFFFF_FFFB, 32'd9, "div_m5_9");
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_max_max");
        run_div(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "div_m1_m1");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> (i * 8);
            if (rb == 32'h0) rb = 32'd3;
            run_div(i[0], ra, rb, "rand");
        end

        // Annul during ON at iteration 10, then a fresh request
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'hFFFF_FFFF;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_int("annul_on busy_before", int'(dif.busy_o), 1);
        dif.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("annul_on");
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, "after_annul_9_3");

        // start and annul together in FREE: ignored
        @(negedge clk);
        dif.opdata1_i = 32'd50;
        dif.opdata2_i = 32'd5;
        dif.start_i   = 1'b1;
        dif.annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("annul_free");
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;

        // Annul in BYZERO
        @(negedge clk);
        dif.opdata1_i = 32'd50;
        dif.opdata2_i = 32'd0;
        dif.start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_int("annul_byzero busy_before", int'(dif.busy_o), 1);
        dif.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("annul_byzero");
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;

        // Annul in END acts like start dropping
        @(negedge clk);
        dif.opdata1_i = 32'd50;
        dif.opdata2_i = 32'd0;
        dif.start_i   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_int("annul_end ready_before", int'(dif.ready_o), 1);
        dif.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("annul_end");
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;

        // Reset mid-division
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_int("rst_mid busy_before", int'(dif.busy_o), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_mid");
        rst         = 1'b0;
        dif.start_i = 1'b0;
        @(posedge clk);
        run_div(1'b0, 32'd100, 32'd7, "after_rst_100_7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
